data_mem: RTL and testbench

DATA_MEM -- requirements
Module: data_mem

---
 rtl/data_mem_if.sv | 29 ++
 rtl/data_mem.sv | 104 ++++++++++
 tb/tb_data_mem.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// Core-to-data-memory request/response bundle. The core acts as master and
// the memory as slave.
interface data_mem_if;

    // A request is taken when valid and the returned yumi are both 1 in the
    // same cycle. A response is held until the core samples valid with its
    // own yumi at 1.
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    typedef struct packed {
        logic [31:0] read_data;
        logic        valid;
        logic        yumi;
    } mem_out_s;

    mem_in_s     mem_in_i;
    logic [31:0] addr_i;
    mem_out_s    mem_out_o;

    modport master (output mem_in_i, output addr_i, input mem_out_o);
    modport slave  (input mem_in_i, input addr_i, output mem_out_o);

endinterface

// File: rtl/data_mem.sv
// Single-port word/byte data memory. It has a fixed response latency and
// holds each response until the core consumes it.
module data_mem #(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    data_mem_if.slave   bus,
    output logic [1:0]  fsm_state
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam int          depth_lp      = 1 << addr_width_p;
    localparam logic [3:0]  count_init_lp = 4'(latency_p - 1);

    logic [1:0]              state_r;
    logic [3:0]              count_r;
    logic [31:0]             read_data_r;
    logic [31:0]             mem_r [depth_lp];

    logic                    accept;
    logic [addr_width_p-1:0] word_idx;
    logic [1:0]              lane;
    logic [31:0]             load_data;

    assign word_idx = bus.addr_i[2 +: addr_width_p];
    assign lane     = bus.addr_i[1:0];
    assign accept   = (state_r == IDLE) && bus.mem_in_i.valid && !reset;

    // Address bits above the array are dropped, so accesses wrap around.
    if (2 + addr_width_p < 32) begin : g_high_addr
        logic unused_high_addr;
        assign unused_high_addr = ^bus.addr_i[31:2+addr_width_p];
    end

    // Stores answer with zero data. Byte loads return the lane zero-extended.
    always_comb begin
        load_data = 32'b0;
        if (!bus.mem_in_i.wen) begin
            if (bus.mem_in_i.byte_not_word)
                load_data = {24'b0, mem_r[word_idx][{lane, 3'b000} +: 8]};
            else
                load_data = mem_r[word_idx];
        end
    end

    // The array has no reset, so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (accept && bus.mem_in_i.wen) begin
            if (bus.mem_in_i.byte_not_word)
                mem_r[word_idx][{lane, 3'b000} +: 8] <= bus.mem_in_i.write_data[7:0];
            else
                mem_r[word_idx] <= bus.mem_in_i.write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            count_r     <= 4'd0;
            read_data_r <= 32'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept) begin
                        read_data_r <= load_data;
                        if (latency_p == 1) begin
                            state_r <= RESP;
                        end else begin
                            state_r <= BUSY;
                            count_r <= count_init_lp;
                        end
                    end
                end
                // One extra BUSY cycle at count 0, so valid rises latency_p edges after acceptance.
                BUSY: begin
                    if (count_r == 4'd0)
                        state_r <= RESP;
                    else
                        count_r <= count_r - 4'd1;
                end
                RESP: begin
                    if (bus.mem_in_i.yumi)
                        state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.mem_out_o           = '0;
        bus.mem_out_o.read_data = read_data_r;
        bus.mem_out_o.valid     = (state_r == RESP);
        bus.mem_out_o.yumi      = (state_r == IDLE) && bus.mem_in_i.valid && !reset;
    end

    assign fsm_state = state_r;

endmodule

// File: tb/tb_data_mem.sv
// Directed checks of data_mem: word/byte access, stall, wrap, reset abort
// and latency sweep.
module tb_data_mem;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic clk;
    logic reset;
    logic [1:0] st2, st1, st4;
    int checks = 0;
    int errors = 0;

    data_mem_if b2();
    data_mem_if b1();
    data_mem_if b4();

    data_mem #(.addr_width_p(10), .latency_p(2)) dut2 (.clk(clk), .reset(reset), .bus(b2), .fsm_state(st2));
    data_mem #(.addr_width_p(10), .latency_p(1)) dut1 (.clk(clk), .reset(reset), .bus(b1), .fsm_state(st1));
    data_mem #(.addr_width_p(10), .latency_p(4)) dut4 (.clk(clk), .reset(reset), .bus(b4), .fsm_state(st4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic drive_req(input logic wen, input logic bnw, input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        b2.mem_in_i.valid         = 1'b1;
        b2.mem_in_i.wen           = wen;
        b2.mem_in_i.byte_not_word = bnw;
        b2.mem_in_i.write_data    = wd;
        b2.addr_i                 = addr;
        #1;
    endtask

    task automatic accept_edge;
        @(posedge clk);
        #1;
        b2.mem_in_i.valid = 1'b0;
        b2.mem_in_i.wen   = 1'b0;
    endtask

    task automatic wait_resp(output int cyc, output logic [31:0] data);
        cyc  = -1;
        data = 32'b0;
        for (int k = 1; k <= 20; k++) begin
            if (cyc < 0) begin
                @(posedge clk);
                #1;
                if (b2.mem_out_o.valid) begin
                    cyc  = k;
                    data = b2.mem_out_o.read_data;
                end
            end
        end
    endtask

    task automatic consume;
        b2.mem_in_i.yumi = 1'b1;
        @(posedge clk);
        #1;
        b2.mem_in_i.yumi = 1'b0;
    endtask

    task automatic xact(input logic wen, input logic bnw, input logic [31:0] addr, input logic [31:0] wd,
                        output int cyc, output logic [31:0] data);
        drive_req(wen, bnw, addr, wd);
        accept_edge();
        wait_resp(cyc, data);
        consume();
    endtask

    task automatic test_reset;
        reset = 1'b1;
        b2.mem_in_i = '0;
        b1.mem_in_i = '0;
        b4.mem_in_i = '0;
        b2.addr_i = 32'h0;
        b1.addr_i = 32'h0;
        b4.addr_i = 32'h0;
        b2.mem_in_i.valid = 1'b1;
        b2.mem_in_i.wen = 1'b1;
        b2.mem_in_i.write_data = 32'h1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (st2 !== IDLE) begin errors++; $display("FAIL reset_state got %0d expected %0d", st2, IDLE); end
        checks++; if (b2.mem_out_o.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b expected 0", b2.mem_out_o.valid); end
        checks++; if (b2.mem_out_o.read_data !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h expected 0", b2.mem_out_o.read_data); end
        checks++; if (b2.mem_out_o.yumi !== 1'b0) begin errors++; $display("FAIL reset_yumi got %b expected 0", b2.mem_out_o.yumi); end
        checks++; if (b4.mem_out_o.valid !== 1'b0) begin errors++; $display("FAIL reset_valid4 got %b expected 0", b4.mem_out_o.valid); end
        reset = 1'b0;
        b2.mem_in_i.valid = 1'b0;
        b2.mem_in_i.wen = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (st2 !== IDLE) begin errors++; $display("FAIL post_reset_state got %0d expected %0d", st2, IDLE); end
    endtask

    task automatic test_word;
        int cyc;
        logic [31:0] data;
        b2.mem_in_i.yumi = 1'b1;
        drive_req(1'b1, 1'b0, 32'h40, 32'hDEADBEEF);
        checks++; if (b2.mem_out_o.yumi !== 1'b1) begin errors++; $display("FAIL word_accept_yumi got %b expected 1", b2.mem_out_o.yumi); end
        accept_edge();
        checks++; if (b2.mem_out_o.yumi !== 1'b0 || st2 !== BUSY) begin errors++; $display("FAIL word_busy got yumi=%b st=%0d expected yumi=0 st=%0d", b2.mem_out_o.yumi, st2, BUSY); end
        wait_resp(cyc, data);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL store_latency got %0d expected 2", cyc); end
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL store_rdata got %h expected 0", data); end
        @(posedge clk);
        #1;
        b2.mem_in_i.yumi = 1'b0;
        checks++; if (st2 !== IDLE || b2.mem_out_o.valid !== 1'b0) begin errors++; $display("FAIL store_idle got st=%0d v=%b expected st=0 v=0", st2, b2.mem_out_o.valid); end
        xact(1'b0, 1'b0, 32'h40, 32'h0, cyc, data);
        checks++; if (data !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load got %h expected deadbeef", data); end
        checks++; if (cyc !== 2) begin errors++; $display("FAIL load_latency got %0d expected 2", cyc); end
    endtask

    task automatic test_byte;
        int cyc;
        logic [31:0] data;
        xact(1'b1, 1'b0, 32'h40, 32'h11223344, cyc, data);
        xact(1'b1, 1'b1, 32'h41, 32'hFFFFFFAB, cyc, data);
        checks++; if (data !== 32'h0) begin errors++; $display("FAIL byte_store_rdata got %h expected 0", data); end
        xact(1'b0, 1'b0, 32'h40, 32'h0, cyc, data);
        checks++; if (data !== 32'h1122AB44) begin errors++; $display("FAIL byte_merge got %h expected 1122ab44", data); end
        xact(1'b0, 1'b1, 32'h41, 32'h0, cyc, data);
        checks++; if (data !== 32'h000000AB) begin errors++; $display("FAIL byte_load_l1 got %h expected 000000ab", data); end
        xact(1'b0, 1'b1, 32'h43, 32'h0, cyc, data);
        checks++; if (data !== 32'h00000011) begin errors++; $display("FAIL byte_load_l3 got %h expected 00000011", data); end
        xact(1'b0, 1'b0, 32'h42, 32'h0, cyc, data);
        checks++; if (data !== 32'h1122AB44) begin errors++; $display("FAIL word_ignore_lane got %h expected 1122ab44", data); end
    endtask

    task automatic test_stall;
        int cyc;
        logic [31:0] data;
        drive_req(1'b0, 1'b0, 32'h40, 32'h0);
        accept_edge();
        wait_resp(cyc, data);
        checks++; if (data !== 32'h1122AB44) begin errors++; $display("FAIL stall_load got %h expected 1122ab44", data); end
        b2.mem_in_i.valid = 1'b1;
        b2.mem_in_i.wen = 1'b1;
        b2.mem_in_i.byte_not_word = 1'b0;
        b2.addr_i = 32'h80;
        b2.mem_in_i.write_data = 32'h77665544;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (b2.mem_out_o.valid !== 1'b1 || b2.mem_out_o.read_data !== 32'h1122AB44 ||
                b2.mem_out_o.yumi !== 1'b0 || st2 !== RESP) begin
                errors++;
                $display("FAIL stall_hold[%0d] got v=%b d=%h y=%b st=%0d expected v=1 d=1122ab44 y=0 st=%0d",
                         i, b2.mem_out_o.valid, b2.mem_out_o.read_data, b2.mem_out_o.yumi, st2, RESP);
            end
            @(posedge clk);
            #1;
        end
        b2.mem_in_i.yumi = 1'b1;
        @(posedge clk);
        #1;
        b2.mem_in_i.yumi = 1'b0;
        checks++; if (st2 !== IDLE || b2.mem_out_o.valid !== 1'b0 || b2.mem_out_o.yumi !== 1'b1) begin
            errors++; $display("FAIL stall_release got st=%0d v=%b y=%b expected st=0 v=0 y=1", st2, b2.mem_out_o.valid, b2.mem_out_o.yumi);
        end
        @(posedge clk);
        #1;
        b2.mem_in_i.valid = 1'b0;
        b2.mem_in_i.wen = 1'b0;
        checks++; if (st2 !== BUSY) begin errors++; $display("FAIL stall_next_accept got %0d expected %0d", st2, BUSY); end
        wait_resp(cyc, data);
        checks++; if (cyc !== 2) begin errors++; $display("FAIL stall_store_latency got %0d expected 2", cyc); end
        consume();
        xact(1'b0, 1'b0, 32'h80, 32'h0, cyc, data);
        checks++; if (data !== 32'h77665544) begin errors++; $display("FAIL stall_store_data got %h expected 77665544", data); end
    endtask

    task automatic test_wrap;
        int cyc;
        logic [31:0] data;
        xact(1'b1, 1'b0, (32'd4 << 10) + 32'd8, 32'h5, cyc, data);
        xact(1'b0, 1'b0, 32'h8, 32'h0, cyc, data);
        checks++; if (data !== 32'h5) begin errors++; $display("FAIL wrap got %h expected 00000005", data); end
    endtask

    task automatic test_reset_abort;
        int cyc;
        int rises;
        logic [31:0] data;
        xact(1'b1, 1'b0, 32'h100, 32'hCAFEF00D, cyc, data);
        drive_req(1'b0, 1'b0, 32'h100, 32'h0);
        accept_edge();
        reset = 1'b1;
        b2.mem_in_i.valid = 1'b1;
        b2.mem_in_i.wen = 1'b1;
        b2.addr_i = 32'h100;
        b2.mem_in_i.write_data = 32'h12345678;
        @(posedge clk);
        #1;
        checks++; if (st2 !== IDLE || b2.mem_out_o.valid !== 1'b0 || b2.mem_out_o.read_data !== 32'h0 || b2.mem_out_o.yumi !== 1'b0) begin
            errors++; $display("FAIL abort_busy got st=%0d v=%b d=%h y=%b expected 0 0 0 0", st2, b2.mem_out_o.valid, b2.mem_out_o.read_data, b2.mem_out_o.yumi);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        b2.mem_in_i.valid = 1'b0;
        b2.mem_in_i.wen = 1'b0;
        rises = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (b2.mem_out_o.valid) rises++;
        end
        checks++; if (rises !== 0) begin errors++; $display("FAIL abort_no_valid got %0d expected 0", rises); end
        drive_req(1'b0, 1'b0, 32'h40, 32'h0);
        accept_edge();
        wait_resp(cyc, data);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        checks++; if (st2 !== IDLE || b2.mem_out_o.valid !== 1'b0) begin errors++; $display("FAIL abort_resp got st=%0d v=%b expected st=0 v=0", st2, b2.mem_out_o.valid); end
        xact(1'b0, 1'b0, 32'h100, 32'h0, cyc, data);
        checks++; if (data !== 32'hCAFEF00D) begin errors++; $display("FAIL abort_data_kept got %h expected cafef00d", data); end
    endtask

    task automatic test_latency;
        int c1;
        int c4;
        @(negedge clk);
        b1.mem_in_i.valid = 1'b1;
        b4.mem_in_i.valid = 1'b1;
        b1.addr_i = 32'h10;
        b4.addr_i = 32'h10;
        @(posedge clk);
        #1;
        b1.mem_in_i.valid = 1'b0;
        b4.mem_in_i.valid = 1'b0;
        c1 = -1;
        c4 = -1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk);
            #1;
            if (c1 < 0 && b1.mem_out_o.valid) c1 = k;
            if (c4 < 0 && b4.mem_out_o.valid) c4 = k;
        end
        checks++; if (c1 !== 1) begin errors++; $display("FAIL latency_1 got %0d expected 1", c1); end
        checks++; if (c4 !== 4) begin errors++; $display("FAIL latency_4 got %0d expected 4", c4); end
        b1.mem_in_i.yumi = 1'b1;
        b4.mem_in_i.yumi = 1'b1;
        @(posedge clk);
        #1;
        b1.mem_in_i.yumi = 1'b0;
        b4.mem_in_i.yumi = 1'b0;
        checks++; if (b1.mem_out_o.valid !== 1'b0 || b4.mem_out_o.valid !== 1'b0) begin
            errors++; $display("FAIL latency_consume got v1=%b v4=%b expected 0 0", b1.mem_out_o.valid, b4.mem_out_o.valid);
        end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_stall();
        test_wrap();
        test_reset_abort();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
